// File: rtl/agc_loop_ctrl.sv
// AGC closed-loop controller: steps a 7-bit PWM threshold toward the power target,
// declares lock with hysteresis, and generates the shadowed PWM gain waveform.
module agc_loop_ctrl #(
  parameter int unsigned TH_INIT = 64,
  parameter int unsigned SKIP_N  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       agc_en,
  input  logic [8:0] pwr_est_dB,
  input  logic       pwr_est_end,
  input  logic [8:0] pwr_target,
  input  logic [3:0] lock_win,
  input  logic [2:0] lock_cnt_th,
  input  logic [1:0] pwm_step,
  input  logic       pwm_ena,
  input  logic       pwm_inv,
  input  logic       pwm_th_ena,
  input  logic [6:0] pwm_th_in,
  input  logic [6:0] pwm_max_val,
  output logic [6:0] pwm_th_out,
  output logic       pwm_out,
  output logic       agc_fix,
  output logic [7:0] pwr_est_val
);

  localparam int unsigned TH_W   = 7;
  localparam int unsigned ERR_W  = 10;
  localparam int unsigned CALC_W = 9;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL} state_t;

  state_t            state, state_nxt;
  logic [1:0]        skip_cnt, skip_nxt;
  logic [2:0]        lock_cnt, lock_nxt;
  logic [ERR_W-1:0]  err, err_nxt;
  logic              fix_nxt;
  logic [TH_W-1:0]   th_nxt;
  logic [7:0]        val_nxt;
  logic [TH_W-1:0]   pwm_cnt, th_shadow;

  // Error magnitude and window classification of the latched estimate
  logic [ERR_W-1:0]  abs_err;
  logic              in_win, hyst_out;
  assign abs_err  = err[ERR_W-1] ? ERR_W'(-err) : err;
  assign in_win   = abs_err <= ERR_W'(lock_win);
  assign hyst_out = abs_err > ERR_W'({lock_win, 1'b0});

  // Candidate threshold in signed 9-bit, then clamped to [0, pwm_max_val]
  logic [3:0]        step_mag;
  logic [CALC_W-1:0] th_ext, th_cand;
  logic [TH_W-1:0]   th_clamp, th_manual;
  logic [2:0]        lock_lim, lock_inc;
  assign step_mag = 4'b0001 << pwm_step;
  assign th_ext   = CALC_W'(pwm_th_out);
  assign th_cand  = in_win      ? th_ext :
                    err[ERR_W-1] ? th_ext + CALC_W'(step_mag) : th_ext - CALC_W'(step_mag);
  assign th_clamp = th_cand[CALC_W-1]                    ? '0 :
                    (th_cand[7:0] > {1'b0, pwm_max_val}) ? pwm_max_val : th_cand[TH_W-1:0];
  assign th_manual = (pwm_th_in < pwm_max_val) ? pwm_th_in : pwm_max_val;
  assign lock_lim  = (lock_cnt_th == 3'd0) ? 3'd1 : lock_cnt_th;
  assign lock_inc  = (lock_cnt == 3'd7) ? 3'd7 : lock_cnt + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      skip_cnt    <= '0;
      lock_cnt    <= '0;
      err         <= '0;
      agc_fix     <= 1'b0;
      pwm_th_out  <= TH_W'(TH_INIT);
      pwr_est_val <= '0;
    end else begin
      state       <= state_nxt;
      skip_cnt    <= skip_nxt;
      lock_cnt    <= lock_nxt;
      err         <= err_nxt;
      agc_fix     <= fix_nxt;
      pwm_th_out  <= th_nxt;
      pwr_est_val <= val_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    lock_nxt  = lock_cnt;
    err_nxt   = err;
    fix_nxt   = agc_fix;
    th_nxt    = pwm_th_out;
    val_nxt   = pwr_est_val;
    if (!agc_en) begin
      state_nxt = S_IDLE;
      skip_nxt  = '0;
      lock_nxt  = '0;
      fix_nxt   = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (pwr_est_end) begin
            if (skip_cnt == 2'd0) begin
              state_nxt = S_EVAL;
              err_nxt   = ERR_W'({1'b0, pwr_est_dB}) - ERR_W'({1'b0, pwr_target});
              val_nxt   = pwr_est_dB[8:1];
            end else begin
              skip_nxt = skip_cnt - 2'd1;
            end
          end
        end
        S_EVAL: begin
          state_nxt = S_WAIT;
          if (!pwm_th_ena) begin
            th_nxt = th_clamp;
            if (th_clamp != pwm_th_out) skip_nxt = 2'(SKIP_N);
            if (in_win) begin
              lock_nxt = lock_inc;
              if (lock_inc >= lock_lim) fix_nxt = 1'b1;
            end else begin
              lock_nxt = '0;
              if (hyst_out) fix_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    // Manual override wins over the loop every cycle
    if (pwm_th_ena) begin
      th_nxt   = th_manual;
      lock_nxt = '0;
      fix_nxt  = 1'b0;
    end
  end

  // PWM: threshold is shadowed at the counter wrap so no period is glitched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt   <= '0;
      th_shadow <= TH_W'(TH_INIT);
      pwm_out   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + TH_W'(1);
      if (pwm_cnt == TH_W'(127)) th_shadow <= pwm_th_out;
      pwm_out <= pwm_ena ? ((pwm_cnt < th_shadow) ^ pwm_inv) : pwm_inv;
    end
  end

endmodule
